gpio_logic_array: RTL and testbench
===================================

Name: gpio_logic_array

Overview:
Parametrised successor to the single-channel two-input registered logic block that is wired to user GPIOs in the openframe wrapper. It provides NCH independent channels. Each channel:
- synchronises and debounces its two GPIO inputs a and b,
- applies a per-channel selectable function (AND/OR/XOR/gated toggle),
- drives a registered output plus an output-enable suitable for gpio_out / gpio_oeb.

It is instantiated in openframe_project_wrapper, with clk and rst sourced from gpio_in pins.

Parameters:
NCH, 4, number of independent channels (1..16).
SYNC_STAGES, 2, synchroniser flops per input bit (>=2).
DB_CYCLES, 4, debounce hold count in cycles; 0 = debounce bypassed.
DB_W, derived = max(1, $clog2(DB_CYCLES+1)), debounce counter width (localparam).

Ports:
clk  input  1  single clock for all state.
rst  input  1  reset, synchronous active-high; all state returns to reset values on the first rising clk edge where rst=1.
a  input  NCH  raw asynchronous GPIO input A per channel.
b  input  NCH  raw asynchronous GPIO input B per channel (second operand / toggle enable).
mode  input  2*NCH  function select; channel c uses mode[2c+1:2c]; treated as quasi-static, registered once.
out  output  NCH  registered channel result, to gpio_out.
oeb  output  NCH  output enable, active-low, to gpio_oeb.

Behaviour:
- Reset (rst=1 at an edge): all synchroniser flops 0, debounced values 0, debounce counters 0, mode register 0, out=0, oeb=all 1. rst mid-operation aborts any pending debounce count. A toggle in progress is lost.
- oeb: 1 during reset; goes to all 0 on the first edge with rst=0, and stays 0 until the next reset.
- Synchroniser: each a[c], b[c] passes through SYNC_STAGES flops. The last stage is s_a[c] / s_b[c].
- Debounce, per bit, DB_CYCLES>0:
  - Holds stable value d and counter cnt.
  - On an edge with s==d: cnt<=0.
  - With s!=d and cnt<DB_CYCLES-1: cnt<=cnt+1.
  - With s!=d and cnt==DB_CYCLES-1: d<=s, cnt<=0.
  - A glitch shorter than DB_CYCLES synced cycles never reaches d; the counter restarts from 0 after any return to d.
- Debounce, DB_CYCLES=0: d is s directly (no counter logic, no added latency).
- Mode register: m[c] <= mode[2c+1:2c] every edge; 1-cycle latency, reset 00.
- Output register, per channel, every edge:
  - 00 AND: out <= da & db.
  - 01 OR: out <= da | db.
  - 10 XOR: out <= da ^ db.
  - 11 TOGGLE: keeps da_prev (reset 0, updated every edge in all modes); if da & ~da_prev & db then out <= ~out, else out holds.
  - Switching into TOGGLE starts from the current out value.
  - A rising da while db=0 is ignored, not queued.
- Latency, from a stable input change (meeting setup before edge 1) to out: SYNC_STAGES + DB_CYCLES + 1 edges. Default = 7. With DB_CYCLES=0 it is SYNC_STAGES+1.
- Simultaneous changes on a and b in the same cycle debounce independently. Equal DB settings give equal latency, so the combinational function sees both new values in the same cycle. No intermediate glitch state appears.
- Channels are fully independent; no cross-channel state.

Test Plan:
- Reset/oeb: rst=1 for 3 cycles, then 0 → out=0 and oeb=4'hF during reset; oeb=4'h0 on the first edge after release; out stays 0 with a=b=0.
- AND latency, defaults: mode=0 (all AND), b=4'hF, a 0→4'h1 held → out[0] rises exactly 7 edges after the change; other bits stay 0.
- Glitch reject: mode=01 (OR) on ch1, a[1] pulsed high for 3 cycles (DB_CYCLES=4) → out[1] never changes. A 4-cycle pulse → out[1] high for exactly 4 cycles, starting 7 edges after the pulse.
- XOR simultaneous: ch2 mode=10, a[2] and b[2] both 0→1 in the same cycle → out[2] stays 0 throughout (no 1-cycle glitch).
- TOGGLE: ch3 mode=11, b[3]=1, five clean a[3] pulses (8 high / 8 low cycles each) → out[3] sequence 1,0,1,0,1. With b[3]=0, two further pulses leave out[3]=1.
- Bypass/reset mid-count: DB_CYCLES=0 build, AND mode, a=b=1 → latency 3 edges. Default build with rst asserted while cnt=2 → after release cnt=0 and a new change again needs the full 7 edges.

Source files
------------

// File: rtl/gpio_logic_array.sv
// rtl/gpio_logic_array.sv - NCH-channel synchronised, debounced two-input logic block for GPIO pins

module gpio_logic_array_db #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic d_o
);
    localparam int DB_W = ($clog2(DB_CYCLES + 1) > 1) ? $clog2(DB_CYCLES + 1) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DB_CYCLES == 0) begin : g_bypass
            assign d_o = s;
        end else begin : g_debounce
            localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

            logic [DB_W-1:0] cnt_q, cnt_d;
            logic            d_q, d_d;

            // Any sample equal to the held value restarts the hold window.
            always_comb begin
                cnt_d = '0;
                d_d   = d_q;
                if (s != d_q) begin
                    if (cnt_q == CNT_MAX) begin
                        d_d = s;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                    d_q   <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    d_q   <= d_d;
                end
            end

            assign d_o = d_q;
        end
    endgenerate
endmodule

module gpio_logic_array #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   a,
    input  logic [NCH-1:0]   b,
    input  logic [2*NCH-1:0] mode,
    output logic [NCH-1:0]   out,
    output logic [NCH-1:0]   oeb
);
    logic [NCH-1:0]   da, db;
    logic [2*NCH-1:0] mode_q;
    logic [NCH-1:0]   da_prev_q;
    logic [NCH-1:0]   out_q, out_d;
    logic [NCH-1:0]   oeb_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        gpio_logic_array_db #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_db_a (
            .clk  (clk),
            .rst  (rst),
            .raw_i(a[c]),
            .d_o  (da[c])
        );

        gpio_logic_array_db #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_db_b (
            .clk  (clk),
            .rst  (rst),
            .raw_i(b[c]),
            .d_o  (db[c])
        );
    end

    always_comb begin
        out_d = out_q;
        for (int c = 0; c < NCH; c++) begin
            case (mode_q[2*c +: 2])
                2'b00: out_d[c] = da[c] & db[c];
                2'b01: out_d[c] = da[c] | db[c];
                2'b10: out_d[c] = da[c] ^ db[c];
                2'b11: begin
                    // Only a rising da seen while db is high toggles; others are dropped.
                    if (da[c] && !da_prev_q[c] && db[c]) begin
                        out_d[c] = ~out_q[c];
                    end
                end
                default: out_d[c] = out_q[c];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= '0;
            da_prev_q <= '0;
            out_q     <= '0;
            oeb_q     <= '1;
        end else begin
            mode_q    <= mode;
            da_prev_q <= da;
            out_q     <= out_d;
            oeb_q     <= '0;
        end
    end

    assign out = out_q;
    assign oeb = oeb_q;
endmodule

// File: tb/tb_gpio_logic_array.sv
// tb/tb_gpio_logic_array.sv - scoreboard bench for gpio_logic_array (default and debounce-bypass builds)

module tb_gpio_logic_array;
    localparam int NCH = 4;
    localparam int SS  = 2;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] a    = '0;
    logic [3:0] b    = '0;
    logic [7:0] mode = '0;
    logic [3:0] out, oeb, out_bp, oeb_bp;

    gpio_logic_array #(.NCH(NCH), .SYNC_STAGES(SS), .DB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .out(out), .oeb(oeb)
    );

    gpio_logic_array #(.NCH(NCH), .SYNC_STAGES(SS), .DB_CYCLES(0)) dut_bp (
        .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .out(out_bp), .oeb(oeb_bp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: index 0 = DB_CYCLES 4, index 1 = DB_CYCLES 0
    bit [SS-1:0] m_sa[2][NCH];
    bit [SS-1:0] m_sb[2][NCH];
    bit          m_da[2][NCH];
    bit          m_db[2][NCH];
    int          m_ca[2][NCH];
    int          m_cb[2][NCH];
    bit          m_prev[2][NCH];
    bit          m_out[2][NCH];
    bit [1:0]    m_mode[2][NCH];
    bit          m_oeb[2];

    typedef struct {
        logic [3:0] out;
        logic [3:0] oeb;
        logic [3:0] out_bp;
        logic [3:0] oeb_bp;
    } exp_t;

    exp_t sb[$];

    function automatic void debounce(input int dbc, input bit s, inout bit d, inout int cnt);
        if (s == d) cnt = 0;
        else if (cnt == dbc - 1) begin
            d   = s;
            cnt = 0;
        end else cnt = cnt + 1;
    endfunction

    task automatic model_step(input bit r, input logic [3:0] av, input logic [3:0] bv, input logic [7:0] mv);
        for (int k = 0; k < 2; k++) begin
            int dbc = (k == 0) ? 4 : 0;
            for (int c = 0; c < NCH; c++) begin
                if (r) begin
                    m_sa[k][c] = '0; m_sb[k][c] = '0;
                    m_da[k][c] = 0;  m_db[k][c] = 0;
                    m_ca[k][c] = 0;  m_cb[k][c] = 0;
                    m_prev[k][c] = 0; m_out[k][c] = 0; m_mode[k][c] = 2'b00;
                end else begin
                    bit sa = m_sa[k][c][SS-1];
                    bit sbb = m_sb[k][c][SS-1];
                    bit ea = (dbc == 0) ? sa : m_da[k][c];
                    bit eb = (dbc == 0) ? sbb : m_db[k][c];
                    case (m_mode[k][c])
                        2'b00: m_out[k][c] = ea & eb;
                        2'b01: m_out[k][c] = ea | eb;
                        2'b10: m_out[k][c] = ea ^ eb;
                        default: if (ea && !m_prev[k][c] && eb) m_out[k][c] = !m_out[k][c];
                    endcase
                    m_prev[k][c] = ea;
                    if (dbc > 0) begin
                        debounce(dbc, sa, m_da[k][c], m_ca[k][c]);
                        debounce(dbc, sbb, m_db[k][c], m_cb[k][c]);
                    end
                    m_sa[k][c] = {m_sa[k][c][SS-2:0], av[c]};
                    m_sb[k][c] = {m_sb[k][c][SS-2:0], bv[c]};
                    m_mode[k][c] = mv[2*c +: 2];
                end
            end
            m_oeb[k] = r;
        end
    endtask

    function automatic logic [3:0] pk_out(input int k);
        logic [3:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_out[k][c];
        return v;
    endfunction

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        model_step(rst, a, b, mode);
        e.out    = pk_out(0);
        e.oeb    = m_oeb[0] ? 4'hF : 4'h0;
        e.out_bp = pk_out(1);
        e.oeb_bp = m_oeb[1] ? 4'hF : 4'h0;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check("sb_out", 32'(out), 32'(e.out));
        check("sb_oeb", 32'(oeb), 32'(e.oeb));
        check("sb_out_bp", 32'(out_bp), 32'(e.out_bp));
        check("sb_oeb_bp", 32'(oeb_bp), 32'(e.oeb_bp));
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse(input int ch, input int w, input int total, output int first, output int highs);
        first = 0;
        highs = 0;
        a[ch] = 1'b1;
        for (int n = 1; n <= total; n++) begin
            if (n == w + 1) a[ch] = 1'b0;
            cyc();
            if (out[ch]) begin
                highs++;
                if (first == 0) first = n;
            end
        end
    endtask

    task automatic measure_rise(output int first, output int first_bp);
        first = 0;
        first_bp = 0;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            if (out[0] && first == 0) first = n;
            if (out_bp[0] && first_bp == 0) first_bp = n;
        end
    endtask

    initial begin
        int f, f_bp, h;
        bit exp_tg[5];
        exp_tg = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_out", 32'(out), 32'h0);
            check("rst_oeb", 32'(oeb), 32'hF);
        end
        rst = 1'b0;
        cyc();
        check("oeb_release", 32'(oeb), 32'h0);
        settle(4);
        check("idle_out", 32'(out), 32'h0);

        b = 4'hF;
        settle(10);
        a = 4'h1;
        measure_rise(f, f_bp);
        check("and_latency", 32'(f), 32'd7);
        check("bypass_latency", 32'(f_bp), 32'd3);
        check("and_other_bits", 32'(out[3:1]), 32'h0);

        a = 4'h0;
        b = 4'h0;
        mode = 8'h04;
        settle(10);
        pulse(1, 3, 16, f, h);
        check("glitch3_highs", 32'(h), 32'd0);
        pulse(1, 4, 16, f, h);
        check("pulse4_start", 32'(f), 32'd7);
        check("pulse4_width", 32'(h), 32'd4);

        mode = 8'h20;
        settle(10);
        a[2] = 1'b1;
        b[2] = 1'b1;
        h = 0;
        for (int n = 0; n < 14; n++) begin
            cyc();
            if (out[2]) h++;
        end
        check("xor_no_glitch", 32'(h), 32'd0);

        a = 4'h0;
        b = 4'h8;
        mode = 8'hC0;
        settle(10);
        for (int i = 0; i < 5; i++) begin
            pulse(3, 8, 16, f, h);
            check($sformatf("toggle_%0d", i), 32'(out[3]), 32'(exp_tg[i]));
        end
        b[3] = 1'b0;
        settle(10);
        for (int i = 0; i < 2; i++) pulse(3, 8, 16, f, h);
        check("toggle_gated", 32'(out[3]), 32'h1);

        mode = 8'h00;
        b = 4'hF;
        settle(10);
        a = 4'h1;
        settle(4);
        rst = 1'b1;
        cyc();
        check("midrst_out", 32'(out), 32'h0);
        check("midrst_oeb", 32'(oeb), 32'hF);
        rst = 1'b0;
        measure_rise(f, f_bp);
        check("midrst_latency", 32'(f), 32'd7);
        check("midrst_bp_latency", 32'(f_bp), 32'd3);
        check("midrst_oeb_after", 32'(oeb), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
